// File: rtl/eight_point_ifft_serial.sv
// Serial 8-point IFFT with 1/8 scaling: bit-reversed load, 12 time-shared radix-2
// DIT butterflies, natural-order unload. Port samples are 16-bit sign-magnitude.
module eight_point_ifft_serial #(
    parameter int IW  = 18,
    parameter int NPT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] in_real,
    input  logic [15:0] in_imag,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_real,
    output logic [15:0] out_imag,
    output logic [2:0]  out_index,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);
    localparam int AW = $clog2(NPT);
    localparam int WX = IW + 1;
    localparam int WW = IW + 2;

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;
    typedef enum logic [1:0] {TW_ONE, TW_C, TW_J, TW_MC} tw_t;

    state_t               state_q;
    logic [3:0]           cnt_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic signed [IW-1:0] re_q [NPT];
    logic signed [IW-1:0] im_q [NPT];

    function automatic logic signed [IW-1:0] sm_to_tc(input logic [15:0] s);
        logic signed [IW-1:0] m;
        m = IW'($signed({1'b0, s[14:0]}));
        return s[15] ? -m : m;
    endfunction

    function automatic logic [15:0] tc_to_sm(input logic signed [IW-1:0] v);
        logic [IW-1:0] mag;
        logic [14:0]   m15;
        mag = v[IW-1] ? IW'(-v) : IW'(v);
        m15 = (mag > IW'(32'd32767)) ? 15'h7FFF : mag[14:0];
        return (m15 == '0) ? 16'h0000 : {v[IW-1], m15};
    endfunction

    // c = 0.70703125 as a shift-add chain
    function automatic logic signed [WX-1:0] cmul(input logic signed [WX-1:0] v);
        return (v >>> 1) + (v >>> 2) - (v >>> 4) + (v >>> 5) - (v >>> 6) + (v >>> 7) - (v >>> 8);
    endfunction

    logic [1:0]           stg;
    logic [1:0]           sel;
    logic [AW-1:0]        a_idx;
    logic [AW-1:0]        b_idx;
    logic [AW-1:0]        ld_addr;
    tw_t                  tw;
    logic signed [IW-1:0] ar, ai, br, bi;
    logic signed [WX-1:0] b_sum, b_dif, c_sum, c_dif;
    logic signed [WW-1:0] tr, ti, pr, pi, mr, mi;
    logic signed [IW-1:0] na_r, na_i, nb_r, nb_i;

    assign stg     = cnt_q[3:2];
    assign sel     = cnt_q[1:0];
    assign ld_addr = {cnt_q[0], cnt_q[1], cnt_q[2]};

    always_comb begin
        a_idx = {sel, 1'b0};
        b_idx = {sel, 1'b1};
        tw    = TW_ONE;
        case (stg)
            2'd1: begin
                a_idx = {sel[1], 1'b0, sel[0]};
                b_idx = {sel[1], 1'b1, sel[0]};
                tw    = sel[0] ? TW_J : TW_ONE;
            end
            2'd2: begin
                a_idx = {1'b0, sel};
                b_idx = {1'b1, sel};
                tw    = tw_t'(sel);
            end
            default: begin end
        endcase

        ar    = re_q[a_idx];
        ai    = im_q[a_idx];
        br    = re_q[b_idx];
        bi    = im_q[b_idx];
        b_sum = WX'(br) + WX'(bi);
        b_dif = WX'(br) - WX'(bi);
        c_sum = cmul(b_sum);
        c_dif = cmul(b_dif);

        tr = WW'(br);
        ti = WW'(bi);
        case (tw)
            TW_C:    begin tr = WW'(c_dif);  ti = WW'(c_sum); end
            TW_J:    begin tr = -WW'(bi);    ti = WW'(br);    end
            TW_MC:   begin tr = -WW'(c_sum); ti = WW'(c_dif); end
            default: begin end
        endcase

        pr   = WW'(ar) + tr;
        pi   = WW'(ai) + ti;
        mr   = WW'(ar) - tr;
        mi   = WW'(ai) - ti;
        na_r = IW'(pr >>> 1);
        na_i = IW'(pi >>> 1);
        nb_r = IW'(mr >>> 1);
        nb_i = IW'(mi >>> 1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: if (in_valid && in_ready_q) begin
                    re_q[ld_addr] <= sm_to_tc(in_real);
                    im_q[ld_addr] <= sm_to_tc(in_imag);
                    if (cnt_q == 4'd7) begin
                        state_q    <= S_COMPUTE;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_COMPUTE: begin
                    re_q[a_idx] <= na_r;
                    im_q[a_idx] <= na_i;
                    re_q[b_idx] <= nb_r;
                    im_q[b_idx] <= nb_i;
                    if (cnt_q == 4'd11) begin
                        state_q     <= S_UNLOAD;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_UNLOAD: if (out_ready) begin
                    if (cnt_q == 4'd7) begin
                        state_q     <= S_LOAD;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    // Output data is read straight from the buffer so the first beat needs no bubble
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_index = out_valid_q ? cnt_q[AW-1:0] : '0;
    assign out_real  = out_valid_q ? tc_to_sm(re_q[cnt_q[AW-1:0]]) : '0;
    assign out_imag  = out_valid_q ? tc_to_sm(im_q[cnt_q[AW-1:0]]) : '0;
    assign done      = out_valid_q & out_ready & (cnt_q[AW-1:0] == 3'd7);

endmodule
